key_event_arbiter: RTL and testbench

- Collects one-cycle press pulses from up to NUM_KEYS per-key debounce instances.
- Holds each press as a pending request until serviced.
- Round-robin arbitrates pending requests into a single event stream, one key index per event, using a valid/ready handshake.
- Sits between the debounce bank and the consumer (LED/display controller or CPU-side register); the debounce bank is never stalled, and merged presses are flagged.

---
 rtl/key_event_arbiter.sv | 93 +++++++++
 tb/tb_key_event_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter.sv
// Captures one-cycle key press pulses as pending requests and serves them
// round-robin, one key index per event, over a registered valid/ready slot.
module key_event_arbiter #(
   parameter int NUM_KEYS = 4,
   parameter int IDX_W    = 2
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic [NUM_KEYS-1:0] Key_Pulse,
   input  logic                Evt_Ready,
   output logic                Evt_Valid,
   output logic [IDX_W-1:0]    Evt_Key,
   output logic [NUM_KEYS-1:0] Pend_Mask,
   output logic                Ovf_Flag,
   input  logic                Ovf_Clr
);

   logic                evt_valid_reg;
   logic [IDX_W-1:0]    evt_key_reg;
   logic [NUM_KEYS-1:0] pend_reg;
   logic [NUM_KEYS-1:0] pend_next;
   logic                ovf_reg;
   logic                ovf_next;
   logic [IDX_W-1:0]    rr_ptr_reg;
   logic [IDX_W-1:0]    rr_ptr_next;

   logic                slot_free;
   logic                grant_vld;
   logic                grant_found;
   logic [IDX_W-1:0]    grant_idx;
   logic [NUM_KEYS-1:0] grant_hot;
   logic [NUM_KEYS-1:0] ovf_hit;
   int                  cand;

   assign slot_free = !evt_valid_reg || Evt_Ready;
   assign grant_vld = slot_free && grant_found;

   // First pending bit at or above rr_ptr, wrapping explicitly at NUM_KEYS.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         cand = int'(rr_ptr_reg) + k;
         if (cand >= NUM_KEYS)
            cand = cand - NUM_KEYS;
         if (!grant_found && pend_reg[cand[IDX_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[IDX_W-1:0];
         end
      end
   end

   // A pulse on the key being granted is a fresh request, not a merge.
   generate
      for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         assign grant_hot[gi] = grant_vld && (grant_idx == IDX_W'(gi));
         assign pend_next[gi] = (pend_reg[gi] && !grant_hot[gi]) || Key_Pulse[gi];
         assign ovf_hit[gi]   = Key_Pulse[gi] && pend_reg[gi] && !grant_hot[gi];
      end
   endgenerate

   assign ovf_next    = (|ovf_hit) ? 1'b1 : (Ovf_Clr ? 1'b0 : ovf_reg);
   assign rr_ptr_next = (int'(grant_idx) == NUM_KEYS - 1) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         evt_valid_reg <= 1'b0;
         evt_key_reg   <= '0;
         pend_reg      <= '0;
         ovf_reg       <= 1'b0;
         rr_ptr_reg    <= '0;
      end else begin
         pend_reg <= pend_next;
         ovf_reg  <= ovf_next;
         if (slot_free) begin
            if (grant_vld) begin
               evt_valid_reg <= 1'b1;
               evt_key_reg   <= grant_idx;
               rr_ptr_reg    <= rr_ptr_next;
            end else begin
               evt_valid_reg <= 1'b0;
            end
         end
      end
   end

   assign Evt_Valid = evt_valid_reg;
   assign Evt_Key   = evt_key_reg;
   assign Pend_Mask = pend_reg;
   assign Ovf_Flag  = ovf_reg;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of pending/round-robin rules.
module tb_key_event_arbiter;

   localparam int N = 4;

   logic         CLK = 1'b0;
   logic         RSTn = 1'b0;
   logic [N-1:0] Key_Pulse = '0;
   logic         Evt_Ready = 1'b0;
   logic         Evt_Valid;
   logic [1:0]   Evt_Key;
   logic [N-1:0] Pend_Mask;
   logic         Ovf_Flag;
   logic         Ovf_Clr = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   // behavioural model state
   bit   m_pend [N];
   int   m_rr;
   bit   m_valid;
   int   m_key;
   bit   m_ovf;

   key_event_arbiter #(.NUM_KEYS(N), .IDX_W(2)) dut (
      .CLK(CLK), .RSTn(RSTn), .Key_Pulse(Key_Pulse), .Evt_Ready(Evt_Ready),
      .Evt_Valid(Evt_Valid), .Evt_Key(Evt_Key), .Pend_Mask(Pend_Mask),
      .Ovf_Flag(Ovf_Flag), .Ovf_Clr(Ovf_Clr)
   );

   always #5 CLK = ~CLK;

   function automatic logic [N-1:0] model_mask();
      logic [N-1:0] m;
      for (int i = 0; i < N; i++) m[i] = m_pend[i];
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_rr = 0; m_valid = 0; m_key = 0; m_ovf = 0;
   endtask

   // One clock of the model: consumer accepts, oldest-in-rotation pending key wins.
   task automatic model_step(input logic [N-1:0] pulse, input bit ready, input bit clr);
      bit free;
      int g;
      bit merged;
      free = !m_valid || ready;
      g = -1;
      if (free)
         for (int k = 0; k < N; k++)
            if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      merged = 0;
      for (int i = 0; i < N; i++)
         if (pulse[i] && m_pend[i] && i != g) merged = 1;
      for (int i = 0; i < N; i++)
         m_pend[i] = (i == g) ? pulse[i] : (m_pend[i] | pulse[i]);
      if (free) begin
         if (g >= 0) begin
            m_valid = 1; m_key = g; m_rr = (g + 1) % N;
         end else begin
            m_valid = 0;
         end
      end
      if (merged) m_ovf = 1;
      else if (clr) m_ovf = 0;
   endtask

   task automatic step(input logic [N-1:0] pulse, input bit ready, input bit clr);
      @(negedge CLK);
      Key_Pulse = pulse; Evt_Ready = ready; Ovf_Clr = clr;
      @(posedge CLK);
      model_step(pulse, ready, clr);
      #1;
      Key_Pulse = '0; Ovf_Clr = 1'b0;
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge CLK);
      RSTn = 1'b0; Key_Pulse = '0; Evt_Ready = 1'b0; Ovf_Clr = 1'b0;
      model_reset();
      repeat (cycles) @(negedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset(3);
      for (int c = 0; c < 10; c++) begin
         step('0, 1'b1, 1'b0);
         vectors++;
         if (Evt_Valid !== 1'b0 || Pend_Mask !== 4'b0000 || Ovf_Flag !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle c%0d: valid=%b pend=%b ovf=%b required 0/0000/0",
                     c, Evt_Valid, Pend_Mask, Ovf_Flag);
         end
      end
      $display("reset_idle: 10 idle cycles checked");
   endtask

   task automatic test_single_press();
      step(4'b0100, 1'b1, 1'b0);
      vectors++;
      if (Pend_Mask !== 4'b0100 || Evt_Valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_pend: pend=%b valid=%b required 0100/0", Pend_Mask, Evt_Valid);
      end
      step('0, 1'b1, 1'b0);
      vectors++;
      if (Evt_Valid !== 1'b1 || Evt_Key !== 2'd2 || Pend_Mask !== 4'b0000) begin
         miscompares++;
         $display("FAIL single_event: valid=%b key=%0d pend=%b required 1/2/0000",
                  Evt_Valid, Evt_Key, Pend_Mask);
      end
      step('0, 1'b1, 1'b0);
      vectors++;
      if (Evt_Valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_drain: valid=%b required 0", Evt_Valid);
      end
      $display("single_press: key2 event checked");
   endtask

   task automatic rr_burst(input string name, input logic [N-1:0] pulse,
                           input int n, input int k0, input int k1, input int k2, input int k3);
      int exp_keys [4];
      exp_keys = '{k0, k1, k2, k3};
      step(pulse, 1'b1, 1'b0);
      for (int e = 0; e < n; e++) begin
         step('0, 1'b1, 1'b0);
         vectors++;
         if (Evt_Valid !== 1'b1 || Evt_Key !== 2'(exp_keys[e])) begin
            miscompares++;
            $display("FAIL %s ev%0d: valid=%b key=%0d required 1/%0d",
                     name, e, Evt_Valid, Evt_Key, exp_keys[e]);
         end
      end
      step('0, 1'b1, 1'b0);
      vectors++;
      if (Evt_Valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s end: valid=%b required 0", name, Evt_Valid);
      end
      $display("%s: pulse %b, %0d events checked", name, pulse, n);
   endtask

   task automatic test_round_robin();
      apply_reset(1);
      rr_burst("rr_all", 4'b1111, 4, 0, 1, 2, 3);
      rr_burst("rr_wrap", 4'b1001, 2, 0, 3, 0, 0);
      rr_burst("rr_key0", 4'b0001, 1, 0, 0, 0, 0);
      rr_burst("rr_ptr1", 4'b1001, 2, 3, 0, 0, 0);
   endtask

   task automatic test_backpressure();
      step(4'b0010, 1'b0, 1'b0);
      step(4'b1000, 1'b0, 1'b0);
      for (int c = 0; c < 20; c++) begin
         vectors++;
         if (Evt_Valid !== 1'b1 || Evt_Key !== 2'd1 || Pend_Mask !== 4'b1000) begin
            miscompares++;
            $display("FAIL backpressure_hold c%0d: valid=%b key=%0d pend=%b required 1/1/1000",
                     c, Evt_Valid, Evt_Key, Pend_Mask);
         end
         step('0, 1'b0, 1'b0);
      end
      step('0, 1'b1, 1'b0);
      vectors++;
      if (Evt_Valid !== 1'b1 || Evt_Key !== 2'd3) begin
         miscompares++;
         $display("FAIL backpressure_release: valid=%b key=%0d required 1/3", Evt_Valid, Evt_Key);
      end
      step('0, 1'b1, 1'b0);
      vectors++;
      if (Evt_Valid !== 1'b0) begin
         miscompares++;
         $display("FAIL backpressure_drain: valid=%b required 0", Evt_Valid);
      end
      $display("backpressure: key1 held 20 cycles, then key3");
   endtask

   task automatic test_overflow();
      int key2_events;
      step(4'b0001, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      vectors++;
      if (Ovf_Flag !== 1'b0 || Pend_Mask !== 4'b0100 || Evt_Key !== 2'd0) begin
         miscompares++;
         $display("FAIL ovf_first: ovf=%b pend=%b key=%0d required 0/0100/0",
                  Ovf_Flag, Pend_Mask, Evt_Key);
      end
      repeat (4) step('0, 1'b0, 1'b0);
      step(4'b0100, 1'b0, 1'b0);
      vectors++;
      if (Ovf_Flag !== 1'b1 || Pend_Mask !== 4'b0100) begin
         miscompares++;
         $display("FAIL ovf_merge: ovf=%b pend=%b required 1/0100", Ovf_Flag, Pend_Mask);
      end
      step(4'b0100, 1'b0, 1'b1);
      vectors++;
      if (Ovf_Flag !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_priority: ovf=%b required 1", Ovf_Flag);
      end
      step('0, 1'b0, 1'b1);
      vectors++;
      if (Ovf_Flag !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_clear: ovf=%b required 0", Ovf_Flag);
      end
      key2_events = 0;
      for (int c = 0; c < 5; c++) begin
         step('0, 1'b1, 1'b0);
         if (Evt_Valid === 1'b1 && Evt_Key === 2'd2) key2_events++;
      end
      vectors++;
      if (key2_events != 1) begin
         miscompares++;
         $display("FAIL ovf_single_event: key2 events=%0d required 1", key2_events);
      end
      $display("overflow: merge, clear priority and single delivery checked");
   endtask

   task automatic test_reset_mid();
      step(4'b0001, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
      step(4'b0110, 1'b0, 1'b0);
      vectors++;
      if (Evt_Valid !== 1'b1 || Pend_Mask !== 4'b0110) begin
         miscompares++;
         $display("FAIL midreset_setup: valid=%b pend=%b required 1/0110", Evt_Valid, Pend_Mask);
      end
      @(negedge CLK);
      RSTn = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (Evt_Valid !== 1'b0 || Evt_Key !== 2'd0 || Pend_Mask !== 4'b0000 || Ovf_Flag !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_async: valid=%b key=%0d pend=%b ovf=%b required all 0",
                  Evt_Valid, Evt_Key, Pend_Mask, Ovf_Flag);
      end
      @(negedge CLK);
      RSTn = 1'b1;
      step(4'b1100, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      vectors++;
      if (Evt_Valid !== 1'b1 || Evt_Key !== 2'd2) begin
         miscompares++;
         $display("FAIL midreset_resume: valid=%b key=%0d required 1/2", Evt_Valid, Evt_Key);
      end
      $display("reset_mid: async clear and resume from key2 checked");
   endtask

   task automatic test_random();
      logic [N-1:0] pulse;
      bit ready, clr;
      int bad;
      apply_reset(2);
      bad = 0;
      for (int c = 0; c < 400; c++) begin
         pulse = '0;
         for (int i = 0; i < N; i++) pulse[i] = ($urandom_range(0, 5) == 0);
         ready = ($urandom_range(0, 2) != 0);
         clr   = ($urandom_range(0, 9) == 0);
         step(pulse, ready, clr);
         vectors++;
         if (Evt_Valid !== m_valid || (m_valid && Evt_Key !== 2'(m_key)) ||
             Pend_Mask !== model_mask() || Ovf_Flag !== m_ovf) begin
            miscompares++;
            bad++;
            if (bad <= 10)
               $display("FAIL random c%0d: valid=%b key=%0d pend=%b ovf=%b required %b/%0d/%b/%b",
                        c, Evt_Valid, Evt_Key, Pend_Mask, Ovf_Flag,
                        m_valid, m_key, model_mask(), m_ovf);
         end
      end
      $display("random: 400 cycles against model");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single_press();
      test_round_robin();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
